pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 178 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//
// Pipeline stage register with valid/ready handshake on both sides. It carries
// a control payload and a data payload between two pipeline stages.
//
// With SKID=1 the stage holds two entries: a main entry that drives the outputs
// and a skid entry. in_ready comes straight from a flop, so there is no
// combinational path from out_ready back to the upstream stage. With SKID=0
// the stage holds one entry and in_ready passes out_ready through
// combinationally.
//
// Whenever no valid entry is presented, out_ctrl shows CTRL_BUBBLE. This keeps
// side-effecting controls (mem write, reg write, jump) from leaking
// downstream.
//
// Parameters
//   DATA_W       width of the data payload (PCs, instruction, immediates, ...)
//   CTRL_W       width of the control payload
//   CTRL_BUBBLE  control encoding of a no-op
//   SKID         1 = two-entry skid buffer, 0 = single-entry register
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   in_valid     upstream offers an entry
//   in_ready     stage accepts an entry this cycle
//   in_ctrl      upstream control payload
//   in_data      upstream data payload
//   flush        synchronous kill of all held entries and of any same-cycle input
//   out_valid    output entry valid
//   out_ready    downstream accepts the output entry
//   out_ctrl     output control payload (CTRL_BUBBLE when out_valid=0)
//   out_data     output data payload (holds last value when empty)
//   occupancy    number of valid entries held
//   bubble_cnt   saturating count of cycles with out_ready=1 and out_valid=0
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int unsigned       DATA_W      = 160,
   parameter int unsigned       CTRL_W      = 16,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
   parameter int unsigned       SKID        = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [15:0]       bubble_cnt
);

   localparam bit UseSkid = (SKID != 0);

   // Main entry: drives the outputs.
   logic              main_valid_q, main_valid_d;
   logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;

   // Skid entry: catches the input accepted while main is stalled.
   logic              skid_valid_q, skid_valid_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;

   logic [15:0]       bubble_cnt_q, bubble_cnt_d;

   logic              in_xfer;
   logic              out_xfer;
   logic              main_free;

   // -------------------------------------------------------------------------
   // Ready generation
   // -------------------------------------------------------------------------
   if (UseSkid) begin : g_skid_ready
      // The skid entry is empty exactly when one more entry can land
      // somewhere, whether or not the main entry drains this cycle.
      assign in_ready = !skid_valid_q;
   end else begin : g_pass_ready
      assign in_ready = !main_valid_q || out_ready;
   end

   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = main_valid_q && out_ready;
   // Main can take a new entry when it is empty or drains at this edge.
   assign main_free = !main_valid_q || out_xfer;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      main_valid_d = main_valid_q;
      main_ctrl_d  = main_ctrl_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;

      if (flush) begin
         // Kill everything, including an input accepted this cycle. Data is
         // left alone since it is meaningless without a valid bit.
         main_valid_d = 1'b0;
         main_ctrl_d  = CTRL_BUBBLE;
         skid_valid_d = 1'b0;
         skid_ctrl_d  = CTRL_BUBBLE;
      end else if (main_free) begin
         if (skid_valid_q) begin
            // Oldest entry first. in_ready is low while skid is full, so no
            // input can arrive in the same cycle.
            main_valid_d = 1'b1;
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = CTRL_BUBBLE;
         end else if (in_xfer) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
         end else begin
            main_valid_d = 1'b0;
            main_ctrl_d  = CTRL_BUBBLE;
         end
      end else if (in_xfer && UseSkid) begin
         // Main is holding a stalled entry; park the new one behind it.
         skid_valid_d = 1'b1;
         skid_ctrl_d  = in_ctrl;
         skid_data_d  = in_data;
      end
   end

   // Bubble counter: saturates, and only reset clears it.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (out_ready && !main_valid_q && (bubble_cnt_q != 16'hFFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_valid_q <= 1'b0;
         main_ctrl_q  <= CTRL_BUBBLE;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_ctrl_q  <= CTRL_BUBBLE;
         skid_data_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_ctrl_q  <= main_ctrl_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_data_q  <= skid_data_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign out_valid  = main_valid_q;
   // The register already holds CTRL_BUBBLE when empty. The mask makes that
   // guarantee independent of how the register got there.
   assign out_ctrl   = main_valid_q ? main_ctrl_q : CTRL_BUBBLE;
   assign out_data   = main_data_q;
   assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. It instantiates one SKID=1 stage with a
// non-zero bubble encoding and one SKID=0 stage. Inputs change on the falling
// edge and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

   localparam int unsigned DW     = 160;
   localparam int unsigned CW     = 16;
   localparam logic [15:0] BUB    = 16'hB0B0;
   localparam logic [15:0] BUB0   = 16'h0000;

   logic          clk;
   logic          reset;

   logic          in_valid, in_ready, flush, out_valid, out_ready;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [DW-1:0] in_data, out_data;
   logic [1:0]    occupancy;
   logic [15:0]   bubble_cnt;

   logic          in_valid0, in_ready0, flush0, out_valid0, out_ready0;
   logic [CW-1:0] in_ctrl0, out_ctrl0;
   logic [DW-1:0] in_data0, out_data0;
   logic [1:0]    occupancy0;
   logic [15:0]   bubble_cnt0;

   int checks;
   int errors;

   pipe_stage_reg #(
      .DATA_W      (DW),
      .CTRL_W      (CW),
      .CTRL_BUBBLE (BUB),
      .SKID        (1)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ctrl    (in_ctrl),
      .in_data    (in_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ctrl   (out_ctrl),
      .out_data   (out_data),
      .occupancy  (occupancy),
      .bubble_cnt (bubble_cnt)
   );

   pipe_stage_reg #(
      .DATA_W      (DW),
      .CTRL_W      (CW),
      .CTRL_BUBBLE (BUB0),
      .SKID        (0)
   ) u_dut0 (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid0),
      .in_ready   (in_ready0),
      .in_ctrl    (in_ctrl0),
      .in_data    (in_data0),
      .flush      (flush0),
      .out_valid  (out_valid0),
      .out_ready  (out_ready0),
      .out_ctrl   (out_ctrl0),
      .out_data   (out_data0),
      .occupancy  (occupancy0),
      .bubble_cnt (bubble_cnt0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] data_of(input logic [15:0] c);
      return {10{c}};
   endfunction

   task automatic test_reset();
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
      checks++; if (out_ctrl !== BUB) begin errors++; $display("FAIL rst_ctrl got=%h exp=%h", out_ctrl, BUB); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", out_data); end
      checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL rst_bcnt got=%0d exp=0", bubble_cnt); end
      // A clock edge with reset still low must not move anything.
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_valid got=%b exp=0", out_valid); end
      checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst0_valid got=%b exp=0", out_valid0); end
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_streaming();
      @(negedge clk);
      in_valid = 1'b1; in_ctrl = 16'd1; in_data = data_of(16'd1); out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", k, out_valid); end
         checks++; if (out_ctrl !== 16'(k)) begin errors++; $display("FAIL stream_ctrl[%0d] got=%0d exp=%0d", k, out_ctrl, k); end
         checks++; if (out_data !== data_of(16'(k))) begin errors++; $display("FAIL stream_data[%0d] got=%h", k, out_data); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got=%b exp=1", k, in_ready); end
         checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got=%0d exp=1", k, occupancy); end
         if (k < 8) begin
            in_ctrl = 16'(k + 1); in_data = data_of(16'(k + 1));
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid got=%b exp=0", out_valid); end
      checks++; if (out_ctrl !== BUB) begin errors++; $display("FAIL stream_end_ctrl got=%h exp=%h", out_ctrl, BUB); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_end_occ got=%0d exp=0", occupancy); end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0011; in_data = data_of(16'h0011);
      @(negedge clk);
      checks++; if (out_ctrl !== 16'h0011) begin errors++; $display("FAIL bp_a_ctrl got=%h exp=0011", out_ctrl); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_a_ready got=%b exp=1", in_ready); end
      in_ctrl = 16'h0012; in_data = data_of(16'h0012);
      @(negedge clk);
      checks++; if (out_ctrl !== 16'h0011) begin errors++; $display("FAIL bp_b_hold got=%h exp=0011", out_ctrl); end
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_b_occ got=%0d exp=2", occupancy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_b_ready got=%b exp=0", in_ready); end
      in_ctrl = 16'h0013; in_data = data_of(16'h0013);
      @(negedge clk);
      checks++; if (out_ctrl !== 16'h0011) begin errors++; $display("FAIL bp_c_hold got=%h exp=0011", out_ctrl); end
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_c_occ got=%0d exp=2", occupancy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_c_ready got=%b exp=0", in_ready); end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_ctrl !== 16'h0012) begin errors++; $display("FAIL bp_out_b got=%h exp=0012", out_ctrl); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ_b got=%0d exp=1", occupancy); end
      @(negedge clk);
      checks++; if (out_ctrl !== 16'h0013) begin errors++; $display("FAIL bp_out_c got=%h exp=0013", out_ctrl); end
      checks++; if (out_data !== data_of(16'h0013)) begin errors++; $display("FAIL bp_data_c got=%h", out_data); end
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got=%b exp=0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0031; in_data = data_of(16'h0031);
      @(negedge clk);
      in_ctrl = 16'h0032; in_data = data_of(16'h0032);
      @(negedge clk);
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL fl_full_occ got=%0d exp=2", occupancy); end
      flush = 1'b1; in_ctrl = 16'h0033; in_data = data_of(16'h0033);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got=%b exp=0", out_valid); end
      checks++; if (out_ctrl !== BUB) begin errors++; $display("FAIL fl_ctrl got=%h exp=%h", out_ctrl, BUB); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL fl_occ got=%0d exp=0", occupancy); end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_ghost[%0d] got=%b exp=0", k, out_valid); end
      end
      // Flush coinciding with an output transfer and an accepted input.
      in_valid = 1'b1; in_ctrl = 16'h0034; in_data = data_of(16'h0034);
      @(negedge clk);
      checks++; if (out_ctrl !== 16'h0034) begin errors++; $display("FAIL fl2_ctrl got=%h exp=0034", out_ctrl); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl2_ready got=%b exp=1", in_ready); end
      flush = 1'b1; in_ctrl = 16'h0035; in_data = data_of(16'h0035);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl2_valid got=%b exp=0", out_valid); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL fl2_occ got=%0d exp=0", occupancy); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl2_ghost got=%b exp=0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_skid0();
      @(negedge clk);
      out_ready0 = 1'b0; in_valid0 = 1'b1; in_ctrl0 = 16'h0021; in_data0 = data_of(16'h0021);
      @(negedge clk);
      checks++; if (out_ctrl0 !== 16'h0021) begin errors++; $display("FAIL s0_ctrl_a got=%h exp=0021", out_ctrl0); end
      checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL s0_ready_stall got=%b exp=0", in_ready0); end
      checks++; if (occupancy0 !== 2'd1) begin errors++; $display("FAIL s0_occ got=%0d exp=1", occupancy0); end
      in_ctrl0 = 16'h0022; in_data0 = data_of(16'h0022);
      @(negedge clk);
      checks++; if (out_ctrl0 !== 16'h0021) begin errors++; $display("FAIL s0_hold got=%h exp=0021", out_ctrl0); end
      out_ready0 = 1'b1;
      #1;
      checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL s0_ready_comb got=%b exp=1", in_ready0); end
      @(negedge clk);
      checks++; if (out_ctrl0 !== 16'h0022) begin errors++; $display("FAIL s0_ctrl_b got=%h exp=0022", out_ctrl0); end
      in_ctrl0 = 16'h0023; in_data0 = data_of(16'h0023);
      @(negedge clk);
      checks++; if (out_ctrl0 !== 16'h0023) begin errors++; $display("FAIL s0_ctrl_c got=%h exp=0023", out_ctrl0); end
      checks++; if (out_data0 !== data_of(16'h0023)) begin errors++; $display("FAIL s0_data_c got=%h", out_data0); end
      in_valid0 = 1'b0;
      @(negedge clk);
      checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL s0_end_valid got=%b exp=0", out_valid0); end
      checks++; if (out_ctrl0 !== BUB0) begin errors++; $display("FAIL s0_end_ctrl got=%h exp=%h", out_ctrl0, BUB0); end
      out_ready0 = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0041; in_data = data_of(16'h0041);
      @(negedge clk);
      in_ctrl = 16'h0042; in_data = data_of(16'h0042);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL ar_full_occ got=%0d exp=2", occupancy); end
      checks++; if (bubble_cnt === 16'd0) begin errors++; $display("FAIL ar_bcnt_pre got=%0d exp=nonzero", bubble_cnt); end
      #2 reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL ar_occ got=%0d exp=0", occupancy); end
      checks++; if (out_ctrl !== BUB) begin errors++; $display("FAIL ar_ctrl got=%h exp=%h", out_ctrl, BUB); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL ar_data got=%h exp=0", out_data); end
      checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL ar_bcnt got=%0d exp=0", bubble_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got=%b exp=1", in_ready); end
      #1 reset = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_after_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_counter();
      @(negedge clk);
      checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL cnt_start got=%0d exp=0", bubble_cnt); end
      out_ready = 1'b1; in_valid = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (bubble_cnt !== 16'd10) begin errors++; $display("FAIL cnt_10 got=%0d exp=10", bubble_cnt); end
      repeat (70000) @(negedge clk);
      checks++; if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got=%0d exp=65535", bubble_cnt); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++; if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_flush got=%0d exp=65535", bubble_cnt); end
      @(negedge clk);
      checks++; if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_nowrap got=%0d exp=65535", bubble_cnt); end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b0;
      in_valid   = 1'b0; in_ctrl  = '0; in_data  = '0; flush  = 1'b0; out_ready  = 1'b0;
      in_valid0  = 1'b0; in_ctrl0 = '0; in_data0 = '0; flush0 = 1'b0; out_ready0 = 1'b0;

      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_skid0();
      test_async_reset();
      test_counter();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
